sram_arbiter: RTL

Single-port SRAM arbiter that shares the 64K x 32 program/data SRAM between the CPU control FSM and the DMA engine. It sits between both requesters and the SRAM macro, and owns sram_ADDR/DI/EN/WE. The CPU has fixed priority, and a starvation guard guarantees the DMA a slot. Read data is returned one cycle after grant, tagged with a valid pulse for the owning requester.

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/arb_starve_counter.sv | 37 +++
 rtl/sram_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: read-owner encoding
// and default bus widths.
package sram_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;
   localparam int STARVE_W   = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } own_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive denied DMA cycles; hit flags
// that the DMA must win the next contended slot.
module arb_starve_counter
   import sram_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

   logic [STARVE_W-1:0] cnt_q;
   logic [STARVE_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != LIM))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign hit = (cnt_q == LIM);

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: CPU fixed priority with a DMA starvation
// guard, zero-latency grants and one-cycle tagged read return.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] sram_ADDR,
   output logic [DATA_W-1:0] sram_DI,
   output logic              sram_EN,
   output logic              sram_WE,
   input  logic [DATA_W-1:0] sram_DO,
   output logic [31:0]       cpu_acc_cnt,
   output logic [31:0]       dma_acc_cnt
);

   logic        starve_hit;
   own_e        rd_own_q;
   own_e        rd_own_d;
   logic [31:0] cpu_cnt_q;
   logic [31:0] cpu_cnt_d;
   logic [31:0] dma_cnt_q;
   logic [31:0] dma_cnt_d;

   // Grants are gated by reset so nothing reaches the macro in reset.
   assign dma_gnt = reset & dma_req & (~cpu_req | starve_hit);
   assign cpu_gnt = reset & cpu_req & ~dma_gnt;

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk   (clk),
      .rst_n (reset),
      .inc   (dma_req & ~dma_gnt),
      .clr   (dma_gnt | ~dma_req),
      .hit   (starve_hit)
   );

   always_comb begin
      sram_EN   = 1'b0;
      sram_WE   = 1'b0;
      sram_ADDR = '0;
      sram_DI   = '0;
      unique case (1'b1)
         cpu_gnt: begin
            sram_EN   = 1'b1;
            sram_WE   = cpu_we;
            sram_ADDR = cpu_addr;
            sram_DI   = cpu_wdata;
         end
         dma_gnt: begin
            sram_EN   = 1'b1;
            sram_WE   = dma_we;
            sram_ADDR = dma_addr;
            sram_DI   = dma_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      rd_own_d  = OWN_NONE;
      if (cpu_gnt && !cpu_we)
         rd_own_d = OWN_CPU;
      else if (dma_gnt && !dma_we)
         rd_own_d = OWN_DMA;
      cpu_cnt_d = cpu_cnt_q + {31'd0, cpu_gnt};
      dma_cnt_d = dma_cnt_q + {31'd0, dma_gnt};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_own_q  <= OWN_NONE;
         cpu_cnt_q <= '0;
         dma_cnt_q <= '0;
      end else begin
         rd_own_q  <= rd_own_d;
         cpu_cnt_q <= cpu_cnt_d;
         dma_cnt_q <= dma_cnt_d;
      end
   end

   assign cpu_rvalid  = (rd_own_q == OWN_CPU);
   assign dma_rvalid  = (rd_own_q == OWN_DMA);
   assign cpu_rdata   = sram_DO;
   assign dma_rdata   = sram_DO;
   assign cpu_acc_cnt = cpu_cnt_q;
   assign dma_acc_cnt = dma_cnt_q;

endmodule
